// File: rtl/line_scheduler.sv
// line_scheduler: round-robin arbiter feeding two line requesters to one drawer.
// Optional power-on frame clear sweep is enabled by defining LINE_SCHED_CLEAR_EN.
module line_scheduler #(
  parameter int WIDTH = 11,
  parameter int XMAX  = 640,
  parameter int YMAX  = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  input  logic [2*WIDTH-1:0] req_x0,
  input  logic [2*WIDTH-1:0] req_y0,
  input  logic [2*WIDTH-1:0] req_x1,
  input  logic [2*WIDTH-1:0] req_y1,
  input  logic [1:0]         req_color,
  output logic [1:0]         req_ready,
  output logic               drw_start,
  output logic [WIDTH-1:0]   drw_x0,
  output logic [WIDTH-1:0]   drw_y0,
  output logic [WIDTH-1:0]   drw_x1,
  output logic [WIDTH-1:0]   drw_y1,
  input  logic [WIDTH-1:0]   drw_x,
  input  logic [WIDTH-1:0]   drw_y,
  input  logic               drw_pix_valid,
  input  logic               drw_done,
  output logic [WIDTH-1:0]   fb_x,
  output logic [WIDTH-1:0]   fb_y,
  output logic               fb_color,
  output logic               fb_write,
  output logic               busy,
  output logic               last_grant
);

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    ISSUE,
    DRAW
  } state_t;

  localparam logic [WIDTH-1:0] XL = WIDTH'(XMAX - 1);
  localparam logic [WIDTH-1:0] YL = WIDTH'(YMAX - 1);

`ifdef LINE_SCHED_CLEAR_EN
  localparam state_t RST_STATE = CLEAR;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_x0;
  logic [WIDTH-1:0] r_y0;
  logic [WIDTH-1:0] r_x1;
  logic [WIDTH-1:0] r_y1;
  logic             r_color;
  logic             r_last;
  logic [1:0]       w_grant;
  logic             w_idx;
  logic             w_accept;
  logic [WIDTH-1:0] w_cx;
  logic [WIDTH-1:0] w_cy;
  logic             w_clr_last;

`ifdef LINE_SCHED_CLEAR_EN
  logic [WIDTH-1:0] r_cx;
  logic [WIDTH-1:0] r_cy;

  // raster counters walk the frame while in CLEAR
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (r_state == CLEAR) begin
      if (w_clr_last) begin
        r_cx <= '0;
        r_cy <= '0;
      end else if (r_cx == XL) begin
        r_cx <= '0;
        r_cy <= r_cy + 1'b1;
      end else begin
        r_cx <= r_cx + 1'b1;
      end
    end
  end

  assign w_cx       = r_cx;
  assign w_cy       = r_cy;
  assign w_clr_last = (r_cx == XL) && (r_cy == YL);
`else
  assign w_cx       = '0;
  assign w_cy       = '0;
  assign w_clr_last = (w_cx <= XL) && (w_cy <= YL);
`endif

  // round-robin pick: on a tie the requester that did not win last time
  always_comb begin
    w_grant = req_valid;
    if (req_valid == 2'b11) begin
      w_grant = r_last ? 2'b01 : 2'b10;
    end
  end

  assign w_idx    = w_grant[1];
  assign w_accept = (r_state == IDLE) && (|req_valid);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      CLEAR:   if (w_clr_last) w_next = IDLE;
      IDLE:    if (|req_valid) w_next = ISSUE;
      ISSUE:   w_next = DRAW;
      DRAW:    if (drw_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // capture the winning request's line and remember who won
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x0    <= '0;
      r_y0    <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
      r_color <= 1'b0;
      r_last  <= 1'b1;
    end else if (w_accept) begin
      r_x0    <= w_idx ? req_x0[2*WIDTH-1:WIDTH] : req_x0[WIDTH-1:0];
      r_y0    <= w_idx ? req_y0[2*WIDTH-1:WIDTH] : req_y0[WIDTH-1:0];
      r_x1    <= w_idx ? req_x1[2*WIDTH-1:WIDTH] : req_x1[WIDTH-1:0];
      r_y1    <= w_idx ? req_y1[2*WIDTH-1:WIDTH] : req_y1[WIDTH-1:0];
      r_color <= w_idx ? req_color[1] : req_color[0];
      r_last  <= w_idx;
    end
  end

  // outputs; all forced quiet while reset is held low
  always_comb begin
    req_ready = 2'b00;
    drw_start = 1'b0;
    fb_write  = 1'b0;
    fb_x      = '0;
    fb_y      = '0;
    fb_color  = 1'b0;
    busy      = 1'b0;
    if (reset) begin
      busy = (r_state != IDLE);
      unique case (r_state)
        CLEAR: begin
          fb_write = 1'b1;
          fb_x     = w_cx;
          fb_y     = w_cy;
        end
        IDLE:  req_ready = w_grant;
        ISSUE: drw_start = 1'b1;
        DRAW: begin
          fb_write = drw_pix_valid;
          fb_x     = drw_x;
          fb_y     = drw_y;
          fb_color = r_color;
        end
        default: ;
      endcase
    end
  end

  assign drw_x0     = r_x0;
  assign drw_y0     = r_y0;
  assign drw_x1     = r_x1;
  assign drw_y1     = r_y1;
  assign last_grant = r_last;

endmodule

// File: tb/tb_line_scheduler.sv
// tb_line_scheduler: directed plus randomized line traffic for line_scheduler.
// Clear-sweep checks are active when LINE_SCHED_CLEAR_EN is defined.
module tb_line_scheduler;
  localparam int W  = 11;
  localparam int XM = 4;
  localparam int YM = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req_valid;
  logic [2*W-1:0] req_x0, req_y0, req_x1, req_y1;
  logic [1:0]     req_color;
  logic [1:0]     req_ready;
  logic           drw_start;
  logic [W-1:0]   drw_x0, drw_y0, drw_x1, drw_y1;
  logic [W-1:0]   drw_x, drw_y;
  logic           drw_pix_valid, drw_done;
  logic [W-1:0]   fb_x, fb_y;
  logic           fb_color, fb_write, busy, last_grant;

  int vectors = 0;
  int miscompares = 0;
  int m_last;
  logic [W-1:0] ex0[2], ey0[2], ex1[2], ey1[2];
  logic         ec[2];

  always #5 clk = ~clk;

  line_scheduler #(.WIDTH(W), .XMAX(XM), .YMAX(YM)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid),
    .req_x0(req_x0), .req_y0(req_y0),
    .req_x1(req_x1), .req_y1(req_y1),
    .req_color(req_color), .req_ready(req_ready),
    .drw_start(drw_start),
    .drw_x0(drw_x0), .drw_y0(drw_y0),
    .drw_x1(drw_x1), .drw_y1(drw_y1),
    .drw_x(drw_x), .drw_y(drw_y),
    .drw_pix_valid(drw_pix_valid), .drw_done(drw_done),
    .fb_x(fb_x), .fb_y(fb_y),
    .fb_color(fb_color), .fb_write(fb_write),
    .busy(busy), .last_grant(last_grant)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // grant rule: lone requester wins; on a tie the one that did not win last
  function automatic int pick(input logic [1:0] v, input int last);
    if (v == 2'b11) return 1 - last;
    return v[1] ? 1 : 0;
  endfunction

  task automatic drive_req();
    req_x0    = {ex0[1], ex0[0]};
    req_y0    = {ey0[1], ey0[0]};
    req_x1    = {ex1[1], ex1[0]};
    req_y1    = {ey1[1], ey1[0]};
    req_color = {ec[1], ec[0]};
  endtask

  task automatic rand_ep();
    for (int i = 0; i < 2; i++) begin
      ex0[i] = W'($urandom_range(0, 2047));
      ey0[i] = W'($urandom_range(0, 2047));
      ex1[i] = W'($urandom_range(0, 2047));
      ey1[i] = W'($urandom_range(0, 2047));
      ec[i]  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic release_rst();
    reset = 1'b1;
    #1;
`ifdef LINE_SCHED_CLEAR_EN
    for (int i = 0; i < XM * YM; i++) begin
      chk("clr_wr", 32'(fb_write), 1);
      chk("clr_x", 32'(fb_x), i % XM);
      chk("clr_y", 32'(fb_y), i / XM);
      chk("clr_col", 32'(fb_color), 0);
      chk("clr_busy", 32'(busy), 1);
      chk("clr_rdy", 32'(req_ready), 0);
      step();
    end
`endif
    chk("rel_busy", 32'(busy), 0);
  endtask

  task automatic do_line(input logic [1:0] v, input int npix);
    int g;
    req_valid = v;
    drive_req();
    #1;
    g = pick(v, m_last);
    chk("ready", 32'(req_ready), 32'(1) << g);
    chk("idle_busy", 32'(busy), 0);
    step();
    m_last = g;
    chk("start", 32'(drw_start), 1);
    chk("x0", 32'(drw_x0), 32'(ex0[g]));
    chk("y0", 32'(drw_y0), 32'(ey0[g]));
    chk("x1", 32'(drw_x1), 32'(ex1[g]));
    chk("y1", 32'(drw_y1), 32'(ey1[g]));
    chk("lastg", 32'(last_grant), g);
    chk("issue_rdy", 32'(req_ready), 0);
    chk("issue_fbw", 32'(fb_write), 0);
    step();
    chk("start_once", 32'(drw_start), 0);
    chk("draw_busy", 32'(busy), 1);
    for (int p = 0; p < npix; p++) begin
      drw_pix_valid = 1'($urandom_range(0, 1));
      drw_x = W'($urandom_range(0, 2047));
      drw_y = W'($urandom_range(0, 2047));
      drw_done = (p == npix - 1);
      if (drw_done) drw_pix_valid = 1'b1;
      #1;
      chk("fbw", 32'(fb_write), 32'(drw_pix_valid));
      if (drw_pix_valid) begin
        chk("fbx", 32'(fb_x), 32'(drw_x));
        chk("fby", 32'(fb_y), 32'(drw_y));
        chk("fbc", 32'(fb_color), 32'(ec[g]));
      end
      chk("hold_x1", 32'(drw_x1), 32'(ex1[g]));
      step();
    end
    drw_done = 1'b0;
    drw_pix_valid = 1'b0;
    chk("done_busy", 32'(busy), 0);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 2'b11;
    drw_x = '0;
    drw_y = '0;
    drw_pix_valid = 1'b0;
    drw_done = 1'b0;
    m_last = 1;
    rand_ep();
    drive_req();
    #12;
    chk("rst_rdy", 32'(req_ready), 0);
    chk("rst_start", 32'(drw_start), 0);
    chk("rst_fbw", 32'(fb_write), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_lastg", 32'(last_grant), 1);
    chk("rst_x0", 32'(drw_x0), 0);
    chk("rst_y1", 32'(drw_y1), 0);
    chk("rst_fbx", 32'(fb_x), 0);
    chk("rst_fby", 32'(fb_y), 0);
    req_valid = 2'b00;
    step();
    release_rst();

    // single request (0,0)-(240,240), colour 1
    ex0[0] = W'(0);
    ey0[0] = W'(0);
    ex1[0] = W'(240);
    ey1[0] = W'(240);
    ec[0]  = 1'b1;
    do_line(2'b01, 6);
    req_valid = 2'b00;

    // contention from a fresh reset: 0,1,0,1
    reset = 1'b0;
    m_last = 1;
    step();
    release_rst();
    for (int k = 0; k < 4; k++) begin
      rand_ep();
      do_line(2'b11, $urandom_range(1, 4));
      chk("rr_seq", 32'(last_grant), k & 1);
    end
    req_valid = 2'b00;

    // stray drawer inputs while idle
    drw_done = 1'b1;
    drw_pix_valid = 1'b1;
    #1;
    chk("stray_fbw", 32'(fb_write), 0);
    chk("stray_busy", 32'(busy), 0);
    step();
    chk("stray_busy2", 32'(busy), 0);
    chk("stray_fbw2", 32'(fb_write), 0);
    drw_done = 1'b0;
    drw_pix_valid = 1'b0;

    // randomized traffic
    for (int n = 0; n < 24; n++) begin
      rand_ep();
      do_line(2'($urandom_range(1, 3)), $urandom_range(1, 6));
      if ($urandom_range(0, 1) == 1) begin
        req_valid = 2'b00;
        step();
      end
    end
    req_valid = 2'b00;
    step();

    // reset in the middle of a line
    rand_ep();
    req_valid = 2'b01;
    drive_req();
    #1;
    chk("mid_rdy", 32'(req_ready), 1);
    step();
    step();
    drw_pix_valid = 1'b1;
    drw_x = W'(5);
    #1;
    chk("mid_fbw", 32'(fb_write), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_fbw", 32'(fb_write), 0);
    chk("mid_rst_start", 32'(drw_start), 0);
    chk("mid_rst_rdy", 32'(req_ready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_lastg", 32'(last_grant), 1);
    chk("mid_rst_x1", 32'(drw_x1), 0);
    drw_pix_valid = 1'b0;
    m_last = 1;
    step();
    release_rst();
    do_line(2'b01, 3);
    req_valid = 2'b00;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
